pyhdl_if_via_event_mux: RTL and testbench

- Parametrised N-channel event concentrator between HDL-side via listener/event producers and a single Python-facing stream consumed through the pyhdl-if call interface.
- Per-channel FIFO buffering, round-robin arbitration and a registered output stage.
- Adds per-channel enable masking, synchronous flush and a saturating delivered-event counter.

---
 rtl/pyhdl_if_via_event_mux.sv | 169 ++++++++++++++++
 tb/tb_pyhdl_if_via_event_mux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pyhdl_if_via_event_mux.sv
// N-channel event concentrator: per-channel FIFOs, round-robin arbitration and
// a registered output stage with enable masking, flush and a saturating counter.
module pyhdl_if_via_event_mux #(
   parameter int N_CHANNELS = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16,
   localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [N_CHANNELS-1:0]        ch_valid,
   output logic [N_CHANNELS-1:0]        ch_ready,
   input  logic [N_CHANNELS*DATA_W-1:0] ch_data,
   input  logic [N_CHANNELS-1:0]        ch_enable,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [CH_W-1:0]              out_chan,
   output logic [CNT_W-1:0]             out_count,
   output logic [N_CHANNELS*LVL_W-1:0]  ch_level
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_W-1:0]                  mem [N_CHANNELS][FIFO_DEPTH];
   logic [N_CHANNELS-1:0][AW-1:0]      rd_ptr;
   logic [N_CHANNELS-1:0][AW-1:0]      wr_ptr;
   logic [N_CHANNELS-1:0][LVL_W-1:0]   level;
   logic [N_CHANNELS-1:0]              full;
   logic [N_CHANNELS-1:0]              eligible;
   logic [N_CHANNELS-1:0]              push;
   logic [N_CHANNELS-1:0]              pop;
   logic [CH_W-1:0]                    rr_ptr;
   logic [CH_W-1:0]                    scan_idx;
   logic [CH_W-1:0]                    grant_idx;
   logic                               grant_hit;
   logic                               load;
   logic [DATA_W-1:0]                  grant_data;

   // Per-channel status: full/eligible flags, ingress accept and push strobes.
   always_comb begin
      full     = '0;
      eligible = '0;
      ch_ready = '0;
      push     = '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
         full[k]     = (level[k] == LVL_W'(FIFO_DEPTH));
         eligible[k] = (level[k] != '0) && ch_enable[k];
         if (reset_n) begin
            ch_ready[k] = ch_enable[k] && !full[k] && !flush;
         end else begin
            ch_ready[k] = 1'b0;
         end
         push[k] = ch_valid[k] && ch_ready[k];
      end
   end

   // Round-robin search: first eligible channel at or above the pointer, wrapping.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         scan_idx = CH_W'((int'(rr_ptr) + i) % N_CHANNELS);
         if (!grant_hit && eligible[scan_idx]) begin
            grant_hit = 1'b1;
            grant_idx = scan_idx;
         end else begin
            grant_hit = grant_hit;
         end
      end
   end

   // Output-stage load decision and the matching one-hot FIFO pop.
   always_comb begin
      load       = !flush && (!out_valid || out_ready) && grant_hit;
      grant_data = mem[grant_idx][rd_ptr[grant_idx]];
      pop        = '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
         if (load && (grant_idx == CH_W'(k))) begin
            pop[k] = 1'b1;
         end else begin
            pop[k] = 1'b0;
         end
      end
   end

   // FIFO payload storage; push already excludes flush and full.
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_CHANNELS; k++) begin
         if (push[k]) begin
            mem[k][wr_ptr[k]] <= ch_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // FIFO pointers and occupancy; flush drops everything buffered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         for (int k = 0; k < N_CHANNELS; k++) begin
            if (flush) begin
               rd_ptr[k] <= '0;
               wr_ptr[k] <= '0;
               level[k]  <= '0;
            end else begin
               if (push[k]) begin
                  wr_ptr[k] <= wr_ptr[k] + AW'(1);
               end
               if (pop[k]) begin
                  rd_ptr[k] <= rd_ptr[k] + AW'(1);
               end
               case ({push[k], pop[k]})
                  2'b10:   level[k] <= level[k] + LVL_W'(1);
                  2'b01:   level[k] <= level[k] - LVL_W'(1);
                  default: level[k] <= level[k];
               endcase
            end
         end
      end
   end

   // Registered output stage and arbitration pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_chan  <= grant_idx;
         if (grant_idx == CH_W'(N_CHANNELS - 1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= grant_idx + CH_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Delivered-event counter: counts every completed handshake, saturates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_count <= '0;
      end else if (out_valid && out_ready && (out_count != {CNT_W{1'b1}})) begin
         out_count <= out_count + CNT_W'(1);
      end
   end

   // Flatten occupancy onto the level port.
   always_comb begin
      ch_level = '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
         ch_level[k*LVL_W +: LVL_W] = level[k];
      end
   end

endmodule

// File: tb/tb_pyhdl_if_via_event_mux.sv
// Directed bench with a queue-based reference model checked every cycle,
// plus literal expectations from the test plan; a CNT_W=4 copy covers saturation.
module tb_pyhdl_if_via_event_mux;
   localparam int N = 4;
   localparam int DW = 32;
   localparam int D = 4;
   localparam int LW = 3;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    ch_valid;
   logic [N-1:0]    ch_ready, sat_ch_ready;
   logic [N*DW-1:0] ch_data;
   logic [N-1:0]    ch_enable;
   logic            flush;
   logic            out_valid, sat_out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data, sat_out_data;
   logic [1:0]      out_chan, sat_out_chan;
   logic [15:0]     out_count;
   logic [3:0]      sat_out_count;
   logic [N*LW-1:0] ch_level, sat_ch_level;

   always #5 clk = ~clk;

   pyhdl_if_via_event_mux dut (
      .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_ready(ch_ready),
      .ch_data(ch_data), .ch_enable(ch_enable), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .out_count(out_count), .ch_level(ch_level));

   pyhdl_if_via_event_mux #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_ready(sat_ch_ready),
      .ch_data(ch_data), .ch_enable(ch_enable), .flush(flush),
      .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
      .out_chan(sat_out_chan), .out_count(sat_out_count), .ch_level(sat_ch_level));

   int passed = 0;
   int total = 0;

   logic [31:0] q [N][$];
   logic        m_valid;
   logic [31:0] m_data;
   int          m_chan, m_ptr, m_count, m_cnt4;
   int          sz [N];
   logic [33:0] log_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_data(input int k, input logic [31:0] v);
      ch_data[k*DW +: DW] = v;
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) q[k].delete();
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0; m_count = 0; m_cnt4 = 0;
   endtask

   task automatic model_step();
      bit found;
      int g;
      if (!reset_n) return;
      if (m_valid && out_ready) begin
         if (m_count < 65535) m_count++;
         if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
         for (int k = 0; k < N; k++) q[k].delete();
         m_valid = 1'b0;
         return;
      end
      for (int k = 0; k < N; k++) sz[k] = q[k].size();
      found = 1'b0; g = 0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_ptr + i) % N;
         if (!found && sz[k] > 0 && ch_enable[k]) begin found = 1'b1; g = k; end
      end
      if ((!m_valid || out_ready) && found) begin
         m_data = q[g].pop_front();
         m_chan = g; m_valid = 1'b1; m_ptr = (g + 1) % N;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      for (int k = 0; k < N; k++)
         if (ch_valid[k] && ch_enable[k] && sz[k] < D) q[k].push_back(ch_data[k*DW +: DW]);
   endtask

   task automatic compare();
      logic [N-1:0] exp_rdy;
      chk("out_valid", out_valid, m_valid);
      chk("sat_out_valid", sat_out_valid, m_valid);
      if (m_valid) begin
         chk("out_data", out_data, m_data);
         chk("out_chan", out_chan, m_chan);
      end
      chk("out_count", out_count, m_count);
      chk("sat_out_count", sat_out_count, m_cnt4);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("ch_level%0d", k), ch_level[k*LW +: LW], q[k].size());
         exp_rdy[k] = reset_n && ch_enable[k] && (q[k].size() < D) && !flush;
      end
      chk("ch_ready", ch_ready, exp_rdy);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic cap_tick();
      if (out_valid && out_ready) log_q.push_back({out_chan, out_data});
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; ch_valid = '0; flush = 1'b0; ch_enable = 4'hF; out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("ready_in_reset", ch_ready, 64'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      ch_data = '0;
      do_reset();
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_out_count", out_count, 64'd0);
      chk("rst_ch_level", ch_level, 64'd0);
      chk("rst_out_chan", out_chan, 64'd0);

      // single event on ch2, two-cycle latency
      out_ready = 1'b1; ch_valid = 4'b0100; set_data(2, 32'hA5A5_0001);
      tick();
      ch_valid = '0;
      chk("t1_not_yet", out_valid, 64'd0);
      chk("t1_level2", ch_level[2*LW +: LW], 64'd1);
      tick();
      chk("t1_valid", out_valid, 64'd1);
      chk("t1_data", out_data, 64'hA5A5_0001);
      chk("t1_chan", out_chan, 64'd2);
      tick();
      chk("t1_count", out_count, 64'd1);

      // round robin over two events per channel
      do_reset();
      ch_valid = 4'hF;
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < N; k++) set_data(k, 32'h1000_0000 + k*256 + j);
         tick();
      end
      ch_valid = '0; out_ready = 1'b1; log_q.delete();
      repeat (10) cap_tick();
      chk("t2_num", log_q.size(), 64'd8);
      for (int i = 0; i < 8 && i < log_q.size(); i++)
         chk($sformatf("t2_ev%0d", i), log_q[i], {2'(i % 4), 32'h1000_0000 + (i % 4)*256 + i/4});
      chk("t2_count", out_count, 64'd8);

      // fill ch1 under back-pressure
      do_reset();
      ch_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin set_data(1, 32'hB000_0000 + i); tick(); end
      chk("t3_level_full", ch_level[1*LW +: LW], 64'd4);
      chk("t3_ready1", ch_ready[1], 64'd0);
      chk("t3_held", out_data, 64'hB000_0000);
      set_data(1, 32'hB000_0005);
      repeat (2) tick();
      chk("t3_refused_level", ch_level[1*LW +: LW], 64'd4);
      chk("t3_stable", out_data, 64'hB000_0000);
      ch_valid = '0; out_ready = 1'b1; log_q.delete();
      repeat (8) cap_tick();
      chk("t3_num", log_q.size(), 64'd5);
      for (int i = 0; i < 5 && i < log_q.size(); i++)
         chk($sformatf("t3_ev%0d", i), log_q[i], {2'd1, 32'hB000_0000 + i});

      // enable masking of ch1
      do_reset();
      ch_valid = 4'b0001; set_data(0, 32'hE000_0000);
      tick();
      ch_valid = 4'b0010; set_data(1, 32'hE000_0001);
      tick();
      ch_enable = 4'b1101; ch_valid = 4'b1000; set_data(3, 32'hE000_0003); out_ready = 1'b1;
      log_q.delete();
      cap_tick();
      ch_valid = '0;
      repeat (4) cap_tick();
      chk("t4_ready1_masked", ch_ready[1], 64'd0);
      chk("t4_level1_kept", ch_level[1*LW +: LW], 64'd1);
      ch_enable = 4'hF;
      repeat (4) cap_tick();
      chk("t4_num", log_q.size(), 64'd3);
      if (log_q.size() == 3) begin
         chk("t4_ev0", log_q[0], {2'd0, 32'hE000_0000});
         chk("t4_ev1", log_q[1], {2'd3, 32'hE000_0003});
         chk("t4_ev2", log_q[2], {2'd1, 32'hE000_0001});
      end

      // flush with three buffered events and a held output
      out_ready = 1'b0; ch_valid = 4'hF;
      for (int k = 0; k < N; k++) set_data(k, 32'hF000_0000 + k);
      tick();
      ch_valid = '0;
      tick();
      chk("t5_valid_before", out_valid, 64'd1);
      flush = 1'b1; ch_valid = 4'hF;
      #1 chk("t5_ready_during_flush", ch_ready, 64'd0);
      tick();
      chk("t5_valid_after", out_valid, 64'd0);
      chk("t5_levels", ch_level, 64'd0);
      chk("t5_count", out_count, 64'd3);
      flush = 1'b0; ch_valid = '0;
      repeat (2) tick();

      // counter saturation on the CNT_W=4 copy
      do_reset();
      out_ready = 1'b1; ch_valid = 4'b0001;
      for (int i = 0; i < 20; i++) begin set_data(0, 32'hC000_0000 + i); tick(); end
      ch_valid = '0;
      repeat (4) tick();
      chk("t6_count20", out_count, 64'd20);
      chk("t6_sat15", sat_out_count, 64'd15);

      // reset asserted mid-transfer
      out_ready = 1'b0; ch_valid = 4'b0011;
      repeat (2) tick();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("t7_valid_rst", out_valid, 64'd0);
      chk("t7_level_rst", ch_level, 64'd0);
      chk("t7_ready_rst", ch_ready, 64'd0);
      @(negedge clk);
      reset_n = 1'b1; ch_valid = '0; out_ready = 1'b1;
      repeat (3) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
